// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back arbiter.
// The optional starvation guard is enabled by defining WB_STARVE_GUARD_EN.
package wb_pkg;

    localparam int unsigned ADR_W_DEF    = 5;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned DEPTH_DEF    = 4;
    localparam int unsigned MAX_WAIT_DEF = 8;

    // Writes to this register are architecturally discarded.
    localparam int unsigned ZERO_REG = 0;

    // One queued long-latency result at the default widths.
    typedef struct packed {
        logic                  live;
        logic [ADR_W_DEF-1:0]  adr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular result queue for long-latency writes, with a parallel WAW kill
// compare and two hazard-match outputs.
module wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADR_W  = ADR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADR_W-1:0]  push_adr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              kill_en_i,
    input  logic [ADR_W-1:0]  kill_adr_i,
    input  logic [ADR_W-1:0]  chk_adr1_i,
    input  logic [ADR_W-1:0]  chk_adr2_i,
    output logic              match1_o,
    output logic              match2_o,
    output logic              head_live_o,
    output logic [ADR_W-1:0]  head_adr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  live_q;
    logic [ADR_W-1:0]  adr_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_q, wr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DEPTH-1:0]  kill_hit;
    logic              push_ok, pop_ok;
    logic              m1, m2;

    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == CNT_W'(DEPTH));
    assign push_ok     = push_i && !full_o;
    assign pop_ok      = pop_i && !empty_o;
    // Slots are cleared on pop, so an empty head always reads as dead.
    assign head_live_o = live_q[rd_q];
    assign head_adr_o  = adr_q[rd_q];
    assign head_data_o = data_q[rd_q];

    // Per-entry address compares: WAW kill vector and hazard matches.
    always_comb begin
        kill_hit = '0;
        m1       = push_ok && (push_adr_i == chk_adr1_i);
        m2       = push_ok && (push_adr_i == chk_adr2_i);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kill_hit[i] = live_q[i] && (adr_q[i] == kill_adr_i);
            if (live_q[i] && (adr_q[i] == chk_adr1_i)) m1 = 1'b1;
            if (live_q[i] && (adr_q[i] == chk_adr2_i)) m2 = 1'b1;
        end
    end

    assign match1_o = m1 && (chk_adr1_i != ADR_W'(ZERO_REG));
    assign match2_o = m2 && (chk_adr2_i != ADR_W'(ZERO_REG));

    // Storage update: kill first, then pop clear, then push (slots never overlap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill_en_i && kill_hit[i]) live_q[i] <= 1'b0;
            end
            if (pop_ok) begin
                live_q[rd_q] <= 1'b0;
                rd_q         <= rd_q + PTR_W'(1);
            end
            if (push_ok) begin
                // A zero destination is stored dead and later popped silently.
                live_q[wr_q] <= (push_adr_i != ADR_W'(ZERO_REG));
                adr_q[wr_q]  <= push_adr_i;
                data_q[wr_q] <= push_data_i;
                wr_q         <= wr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: sole driver of the register file write port. Merges the
// non-stalling pipeline WB stage with queued long-latency results.
// Define WB_STARVE_GUARD_EN to enable the queue starvation guard (stall_req).
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned ADR_W    = ADR_W_DEF,
`ifdef WB_STARVE_GUARD_EN
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
`endif
    parameter int unsigned DATA_W   = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wr_en,
    input  logic [ADR_W-1:0]  pipe_wr_adr,
    input  logic [DATA_W-1:0] pipe_wr_data,
    input  logic              ml_valid,
    output logic              ml_ready,
    input  logic [ADR_W-1:0]  ml_adr,
    input  logic [DATA_W-1:0] ml_data,
    input  logic [ADR_W-1:0]  chk_adr1,
    input  logic [ADR_W-1:0]  chk_adr2,
    output logic              chk_pending1,
    output logic              chk_pending2,
    output logic              regWrite,
    output logic [ADR_W-1:0]  writeAdr,
    output logic [DATA_W-1:0] writeData,
    output logic              stall_req
);

    logic              pipe_eff, head_write, pop, empty, full;
    logic              head_live;
    logic [ADR_W-1:0]  head_adr;
    logic [DATA_W-1:0] head_data;

    assign pipe_eff   = pipe_wr_en && (pipe_wr_adr != ADR_W'(ZERO_REG));
    assign ml_ready   = !full;
    assign head_write = !empty && head_live && (head_adr != ADR_W'(ZERO_REG));
    // Dead heads leave even when the pipeline owns the port; live ones need the slot.
    assign pop        = !empty && (!head_write || !pipe_eff);

    wb_queue #(
        .DEPTH  (DEPTH),
        .ADR_W  (ADR_W),
        .DATA_W (DATA_W)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ml_valid && ml_ready),
        .push_adr_i  (ml_adr),
        .push_data_i (ml_data),
        .pop_i       (pop),
        .kill_en_i   (pipe_eff),
        .kill_adr_i  (pipe_wr_adr),
        .chk_adr1_i  (chk_adr1),
        .chk_adr2_i  (chk_adr2),
        .match1_o    (chk_pending1),
        .match2_o    (chk_pending2),
        .head_live_o (head_live),
        .head_adr_o  (head_adr),
        .head_data_o (head_data),
        .empty_o     (empty),
        .full_o      (full)
    );

    // Registered write port; address/data hold when no write is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite  <= 1'b0;
            writeAdr  <= '0;
            writeData <= '0;
        end else if (pipe_eff) begin
            regWrite  <= 1'b1;
            writeAdr  <= pipe_wr_adr;
            writeData <= pipe_wr_data;
        end else if (head_write) begin
            regWrite  <= 1'b1;
            writeAdr  <= head_adr;
            writeData <= head_data;
        end else begin
            regWrite  <= 1'b0;
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              stall_q, stall_d;

    // Count cycles the head waits; saturate at MAX_WAIT, flag until next pop.
    always_comb begin
        wait_d  = wait_q;
        stall_d = stall_q;
        if (empty || pop) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        if (pop) begin
            stall_d = 1'b0;
        end else if (wait_d == WAIT_W'(MAX_WAIT)) begin
            stall_d = 1'b1;
        end
    end

    // Starve guard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign stall_req = stall_q;
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_adr;
    logic [31:0] pipe_wr_data;
    logic        ml_valid;
    logic        ml_ready;
    logic [4:0]  ml_adr;
    logic [31:0] ml_data;
    logic [4:0]  chk_adr1, chk_adr2;
    logic        chk_pending1, chk_pending2;
    logic        regWrite;
    logic [4:0]  writeAdr;
    logic [31:0] writeData;
    logic        stall_req;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_wr_adr  (pipe_wr_adr),
        .pipe_wr_data (pipe_wr_data),
        .ml_valid     (ml_valid),
        .ml_ready     (ml_ready),
        .ml_adr       (ml_adr),
        .ml_data      (ml_data),
        .chk_adr1     (chk_adr1),
        .chk_adr2     (chk_adr2),
        .chk_pending1 (chk_pending1),
        .chk_pending2 (chk_pending2),
        .regWrite     (regWrite),
        .writeAdr     (writeAdr),
        .writeData    (writeData),
        .stall_req    (stall_req)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: an ordered list of pending results.
    typedef struct packed {
        logic        live;
        logic [4:0]  adr;
        logic [31:0] data;
    } ment_t;

    ment_t       mq[$];
    logic        exp_we, exp_ready, exp_p1, exp_p2, exp_stall;
    logic [4:0]  exp_adr;
    logic [31:0] exp_data;
    int          m_wait;
    logic        obs_ready, obs_p1, obs_p2;

    task automatic model_reset();
        mq.delete();
        exp_we    = 1'b0;
        exp_adr   = '0;
        exp_data  = '0;
        exp_stall = 1'b0;
        m_wait    = 0;
    endtask

    function automatic logic model_pending(logic [4:0] c, logic acc, logic [4:0] ma);
        if (c == 5'd0) return 1'b0;
        if (acc && ma == c) return 1'b1;
        foreach (mq[i]) if (mq[i].live && mq[i].adr == c) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle, capture combinational outputs, advance model and DUT.
    task automatic cycle(input logic en, input logic [4:0] a, input logic [31:0] d,
                         input logic v, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] c1, input logic [4:0] c2);
        logic  acc, pe, hw, pop;
        ment_t e;
        pipe_wr_en = en; pipe_wr_adr = a; pipe_wr_data = d;
        ml_valid = v; ml_adr = ma; ml_data = md;
        chk_adr1 = c1; chk_adr2 = c2;
        #1;
        obs_ready = ml_ready;
        obs_p1    = chk_pending1;
        obs_p2    = chk_pending2;
        exp_ready = (mq.size() < DEPTH);
        acc       = v && exp_ready;
        exp_p1    = model_pending(c1, acc, ma);
        exp_p2    = model_pending(c2, acc, ma);
        pe  = en && (a != 5'd0);
        hw  = (mq.size() > 0) && mq[0].live;
        pop = (mq.size() > 0) && (!hw || !pe);
        if (pe) begin
            exp_we = 1'b1; exp_adr = a; exp_data = d;
        end else if (hw) begin
            exp_we = 1'b1; exp_adr = mq[0].adr; exp_data = mq[0].data;
        end else begin
            exp_we = 1'b0;
        end
        if (GUARD_EN) begin
            if (pop || mq.size() == 0) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
            if (pop) exp_stall = 1'b0;
            else if (m_wait == MAX_WAIT) exp_stall = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (pe) begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (e.live && e.adr == a) begin
                    e.live = 1'b0;
                    mq[i]  = e;
                end
            end
        end
        if (acc) mq.push_back({(ma != 5'd0), ma, md});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        pipe_wr_en = 1'b0; pipe_wr_adr = '0; pipe_wr_data = '0;
        ml_valid = 1'b0; ml_adr = '0; ml_data = '0; chk_adr1 = '0; chk_adr2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (regWrite !== 1'b0) $display("FAIL reset_regWrite got %b want 0", regWrite);
        else passes++;
        checks++;
        if (writeAdr !== 5'd0) $display("FAIL reset_writeAdr got %0d want 0", writeAdr);
        else passes++;
        checks++;
        if (writeData !== 32'd0) $display("FAIL reset_writeData got %h want 0", writeData);
        else passes++;
        checks++;
        if (ml_ready !== 1'b1) $display("FAIL reset_ml_ready got %b want 1", ml_ready);
        else passes++;
        checks++;
        if (stall_req !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_req);
        else passes++;
    endtask

    task automatic test_pipe_write();
        cycle(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++;
        if ({regWrite, writeAdr, writeData} !== {1'b1, 5'd3, 32'h55})
            $display("FAIL pipe_write got we=%b adr=%0d data=%h want we=1 adr=3 data=55",
                     regWrite, writeAdr, writeData);
        else passes++;
        idle();
        checks++;
        if ({regWrite, writeAdr} !== {1'b0, 5'd3})
            $display("FAIL pipe_idle got we=%b adr=%0d want we=0 adr=3", regWrite, writeAdr);
        else passes++;
    endtask

    task automatic test_zero_adr();
        cycle(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++;
        if ({regWrite, writeData} !== {1'b0, 32'h55})
            $display("FAIL zero_adr got we=%b data=%h want we=0 data=55", regWrite, writeData);
        else passes++;
    endtask

    task automatic test_queue_full();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(4 + i), 32'(256 + i), 5'd0, 5'd0);
            checks++;
            if (obs_ready !== 1'b1) $display("FAIL fill_ready%0d got %b want 1", i, obs_ready);
            else passes++;
        end
        cycle(1'b1, 5'd24, 32'd0, 1'b1, 5'd8, 32'h999, 5'd0, 5'd0);
        checks++;
        if (obs_ready !== 1'b0) $display("FAIL full_ready got %b want 0", obs_ready);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            idle();
            checks++;
            if ({regWrite, writeAdr, writeData} !== {1'b1, 5'(4 + i), 32'(256 + i)})
                $display("FAIL drain%0d got we=%b adr=%0d data=%h want we=1 adr=%0d data=%h",
                         i, regWrite, writeAdr, writeData, 4 + i, 256 + i);
            else passes++;
        end
        idle();
        checks++;
        if ({obs_ready, regWrite} !== 2'b10)
            $display("FAIL drained got ready=%b we=%b want ready=1 we=0", obs_ready, regWrite);
        else passes++;
    endtask

    task automatic test_waw();
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'd1, 5'd9, 5'd0);
        checks++;
        if (obs_p1 !== 1'b1) $display("FAIL waw_enq_pending got %b want 1", obs_p1);
        else passes++;
        cycle(1'b1, 5'd9, 32'd2, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        checks++;
        if ({regWrite, writeAdr, writeData} !== {1'b1, 5'd9, 32'd2})
            $display("FAIL waw_pipe got we=%b adr=%0d data=%h want we=1 adr=9 data=2",
                     regWrite, writeAdr, writeData);
        else passes++;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        checks++;
        if (obs_p1 !== 1'b0) $display("FAIL waw_killed_pending got %b want 0", obs_p1);
        else passes++;
        checks++;
        if ({regWrite, writeData} !== {1'b0, 32'd2})
            $display("FAIL waw_silent_pop got we=%b data=%h want we=0 data=2", regWrite, writeData);
        else passes++;
        idle();
        checks++;
        if ({obs_ready, regWrite} !== 2'b10)
            $display("FAIL waw_after got ready=%b we=%b want ready=1 we=0", obs_ready, regWrite);
        else passes++;
    endtask

    task automatic test_pending();
        cycle(1'b1, 5'd1, 32'hA, 1'b1, 5'd12, 32'h77, 5'd12, 5'd0);
        checks++;
        if ({obs_p1, obs_p2} !== 2'b10)
            $display("FAIL pend_enq got p1=%b p2=%b want p1=1 p2=0", obs_p1, obs_p2);
        else passes++;
        cycle(1'b1, 5'd1, 32'hB, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
        checks++;
        if ({obs_p1, obs_p2} !== 2'b10)
            $display("FAIL pend_queued got p1=%b p2=%b want p1=1 p2=0", obs_p1, obs_p2);
        else passes++;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
        checks++;
        if ({regWrite, writeAdr, writeData} !== {1'b1, 5'd12, 32'h77})
            $display("FAIL pend_drain got we=%b adr=%0d data=%h want we=1 adr=12 data=77",
                     regWrite, writeAdr, writeData);
        else passes++;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
        checks++;
        if ({obs_p1, obs_p2} !== 2'b00)
            $display("FAIL pend_after got p1=%b p2=%b want 0 0", obs_p1, obs_p2);
        else passes++;
    endtask

    task automatic test_starve();
        logic want;
        cycle(1'b1, 5'd1, 32'd0, 1'b1, 5'd13, 32'h1313, 5'd0, 5'd0);
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1, 5'd2, 32'(k), 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
            want = GUARD_EN && (k >= MAX_WAIT);
            checks++;
            if (stall_req !== want) $display("FAIL starve_wait%0d got %b want %b", k, stall_req, want);
            else passes++;
        end
        idle();
        checks++;
        if ({regWrite, writeAdr, stall_req} !== {1'b1, 5'd13, 1'b0})
            $display("FAIL starve_pop got we=%b adr=%0d stall=%b want we=1 adr=13 stall=0",
                     regWrite, writeAdr, stall_req);
        else passes++;
    endtask

    task automatic test_random();
        logic        en, v;
        logic [4:0]  a, ma, c1, c2;
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 99) < 60);
            v  = ($urandom_range(0, 99) < 55);
            a  = 5'($urandom_range(0, 7));
            ma = 5'($urandom_range(0, 7));
            c1 = 5'($urandom_range(0, 7));
            c2 = 5'($urandom_range(0, 7));
            cycle(en, a, $urandom, v, ma, $urandom, c1, c2);
            checks++;
            if ({obs_ready, obs_p1, obs_p2} !== {exp_ready, exp_p1, exp_p2})
                $display("FAIL rnd_comb%0d got ready=%b p1=%b p2=%b want %b %b %b",
                         n, obs_ready, obs_p1, obs_p2, exp_ready, exp_p1, exp_p2);
            else passes++;
            checks++;
            if ({regWrite, writeAdr, writeData, stall_req} !==
                {exp_we, exp_adr, exp_data, exp_stall})
                $display("FAIL rnd_out%0d got we=%b adr=%0d data=%h stall=%b want %b %0d %h %b",
                         n, regWrite, writeAdr, writeData, stall_req,
                         exp_we, exp_adr, exp_data, exp_stall);
            else passes++;
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'd1, 32'(i), 1'b1, 5'(28 + i), 32'(i), 5'd0, 5'd0);
        end
        chk_adr1 = 5'd29;
        rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if ({regWrite, ml_ready, chk_pending1} !== 3'b010)
            $display("FAIL midrst got we=%b ready=%b p1=%b want we=0 ready=1 p1=0",
                     regWrite, ml_ready, chk_pending1);
        else passes++;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if ({regWrite, writeAdr} !== {1'b0, 5'd0})
                $display("FAIL midrst_lost%0d got we=%b adr=%0d want we=0 adr=0",
                         i, regWrite, writeAdr);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_zero_adr();
        test_queue_full();
        test_waw();
        test_pending();
        test_starve();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
